mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single synchronous memory port (address/data_out/data_in/we) between two requesters:
//  m0 = core load/store/fetch, m1 = debug/program-loader.
//  Sequences each access through an FSM and inserts MEM_LATENCY wait cycles for slower memories.
//  Returns read data with a one-cycle valid pulse.
//  Sits between the multicycle core (via a req/gnt shim) and the memory model.
// PARAMETERS
//  AW           32  address width
//  DW           32  data width
//  MEM_LATENCY   0  extra cycles after the ACCESS cycle before mem_data_in is valid (0..15)
// PORTS
//  clk           in   1   clock
//  resetn        in   1   synchronous, active-low reset
//  m0_req        in   1   m0 access request; held until m0_gnt
//  m0_we         in   1   m0 write (1) / read (0)
//  m0_addr       in   AW  m0 address
//  m0_wdata      in   DW  m0 write data
//  m0_gnt        out  1   one-cycle pulse: m0 request accepted, fields latched
//  m0_rvalid     out  1   one-cycle pulse: m0_rdata valid
//  m0_rdata      out  DW  m0 read data (registered)
//  m1_*          --   --  identical set for requester 1
//  mem_address   out  AW  memory address
//  mem_data_out  out  DW  memory write data
//  mem_we        out  1   memory write enable
//  mem_data_in   in   DW  memory read data
// BEHAVIOUR
//  - Reset: state IDLE; gnt/rvalid/mem_we = 0; mem_address, mem_data_out, rdata = 0; wait counter = 0; RR pointer = m1.
//  - FSM: IDLE -> ACCESS -> {IDLE on write | WAIT (MEM_LATENCY>0) | RESP (MEM_LATENCY=0)}; WAIT -> RESP after MEM_LATENCY cycles; RESP -> IDLE.
//  - IDLE: if any req, winner's gnt is asserted combinationally this cycle. addr/we/wdata/owner are latched at the edge and the FSM goes to ACCESS.
//  - ACCESS: mem_address/mem_data_out driven from the latched regs; mem_we = latched we for exactly this one cycle.
//  - Read sampling: mem_data_in is captured into the owner's rdata at the edge ending cycle ACCESS+MEM_LATENCY. mem_address is held stable through WAIT.
//  - RESP: owner's rvalid = 1 for one cycle; the other requester's rvalid/rdata are unchanged.
//  - Latency, req to rvalid: read = 2+MEM_LATENCY cycles. Write = gnt same cycle, mem_we next cycle, no rvalid.
//  - Throughput: one access per 2 cycles for writes, 3+MEM_LATENCY for reads. Requests arriving outside IDLE wait; no gnt is issued outside IDLE.
//  - Requester rules: fields stable while req=1 and gnt=0. Dropping req before gnt withdraws it. req still high in the cycle after gnt is a new request.
//  - Simultaneous req: fixed priority, m0 wins (see CONFIGURATION).
//  - Wait counter width: $clog2(MEM_LATENCY+1). Counts down from MEM_LATENCY; no wrap.
//  - Reset mid-operation: abort to IDLE. mem_we = 0 from the next cycle; no rvalid for the aborted access.
//  - mem_address/mem_data_out hold the last latched values while IDLE; mem_we = 0 outside ACCESS.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. On simultaneous req, the requester NOT granted last wins. The pointer updates on each gnt and resets to "m1 last", so m0 wins first.
//  MEM_ARB_RR_EN undefined: fixed priority, m0 always wins; the pointer logic is removed.
// STRUCTURE
//  Package mem_arb_pkg:
//   - state encoding: IDLE, ACCESS, WAIT, RESP (2-bit)
//   - owner encoding: OWN_M0 = 0, OWN_M1 = 1
//  Sub-module mem_arb_pick: combinational winner select (req0, req1, last_owner -> gnt0, gnt1); holds the RR/fixed ifdef.
//  Top: FSM, latches, wait counter, rdata/rvalid registers.
// TESTING
//  1. MEM_LATENCY=0, m0 read addr 0x10, mem returns 0xDEADBEEF -> m0_gnt @t0, mem_address=0x10 @t1, m0_rvalid @t2, m0_rdata=0xDEADBEEF.
//  2. m1 write addr 0x20 data 0x12345678 -> m1_gnt @t0; mem_we=1, mem_address=0x20, mem_data_out=0x12345678 @t1 only; no m1_rvalid.
//  3. Both req read continuously, fixed priority -> m0 granted every IDLE; with MEM_ARB_RR_EN -> grants alternate m0,m1,m0,m1.
//  4. MEM_LATENCY=3, m0 read 0x40 -> mem_address=0x40 held 4 cycles, m0_rvalid at t5 with data present at the end of t4.
//  5. resetn=0 during WAIT of a read -> next cycle IDLE, mem_we=0, no rvalid; a following m1 read completes normally.
//  6. m1 raises req while m0's access is in progress, then drops it before IDLE -> no m1_gnt, no memory access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and access owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between two requesters; zero latency, no state.
// MEM_ARB_RR_EN selects round-robin on collision, otherwise m0 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t last_owner,
    output logic   gnt0,
    output logic   gnt1
);

`ifdef MEM_ARB_RR_EN
    // On a collision the requester that was not served last goes first.
    always_comb begin
        gnt0 = req0 && (!req1 || (last_owner == OWN_M1));
        gnt1 = req1 && (!req0 || (last_owner == OWN_M0));
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        gnt0 = req0;
        gnt1 = req1 && !req0;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between m0 and m1; read req->rvalid 2+MEM_LATENCY cycles,
// writes take 2 cycles; requests are held off (no gnt) until IDLE. MEM_ARB_RR_EN enables round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LATENCY = 0
)
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_out,
    output logic          mem_we,
    input  logic [DW-1:0] mem_data_in
);

    localparam int            CW  = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

    state_t        state;
    state_t        state_nxt;
    owner_t        owner;
    owner_t        last_owner;
    logic          we_q;
    logic [CW-1:0] wait_cnt;
    logic          pick0;
    logic          pick1;
    logic          grant;

    mem_arb_pick u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_owner (last_owner),
        .gnt0       (pick0),
        .gnt1       (pick1)
    );

    assign grant = (state == IDLE) && (pick0 || pick1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (m0_req || m1_req) state_nxt = ACCESS;
            ACCESS: begin
                if (we_q)                  state_nxt = IDLE;
                else if (MEM_LATENCY == 0) state_nxt = RESP;
                else                       state_nxt = WAIT;
            end
            WAIT:   if (wait_cnt == CW'(1)) state_nxt = RESP;
            RESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        if (state == IDLE) begin
            m0_gnt = pick0;
            m1_gnt = pick1;
        end
        mem_we    = (state == ACCESS) && we_q;
        m0_rvalid = (state == RESP) && (owner == OWN_M0);
        m1_rvalid = (state == RESP) && (owner == OWN_M1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner        <= OWN_M0;
            we_q         <= 1'b0;
            mem_address  <= '0;
            mem_data_out <= '0;
            wait_cnt     <= '0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
        end else begin
            if (grant) begin
                owner        <= pick1 ? OWN_M1 : OWN_M0;
                we_q         <= pick1 ? m1_we : m0_we;
                mem_address  <= pick1 ? m1_addr : m0_addr;
                mem_data_out <= pick1 ? m1_wdata : m0_wdata;
            end
            if (state == ACCESS) begin
                wait_cnt <= LAT;
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - CW'(1);
            end
            // Entering RESP marks the last cycle in which mem_data_in is valid.
            if (state_nxt == RESP) begin
                if (owner == OWN_M0) m0_rdata <= mem_data_in;
                else                 m1_rdata <= mem_data_in;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_owner <= OWN_M1;
        end else if (grant) begin
            last_owner <= pick1 ? OWN_M1 : OWN_M0;
        end
    end
`else
    assign last_owner = OWN_M1;
`endif

endmodule
